complete_multi: RTL and testbench
=================================

Name: complete_multi

Overview:
Parametrised multi-lane complete stage between the execute lanes and the CDB/retire stage.
- Each execute lane deposits finished EX_CO_PACKETs into a small per-lane holding FIFO.
- A round-robin arbiter broadcasts up to CDB_WIDTH results per cycle as registered CO_RE_PACKETs.
- The functional units of broadcast results are released with one-cycle free pulses.
- Lane backpressure and squash on mispredict are provided, which the single-lane pass-through stage does not have.

Parameters:
NUM_LANES, 4, number of execute lanes feeding the stage
CDB_WIDTH, 2, results broadcast per cycle (1..NUM_LANES)
BUF_DEPTH, 2, entries per lane FIFO (power of two, >=2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = in reset)
squash_en  input  1  mispredict flush, synchronous
lane_valid  input  NUM_LANES  lane i presents a finished instruction
lane_packet  input  NUM_LANES x EX_CO_PACKET  per-lane execute result
lane_ready  output  NUM_LANES  lane i FIFO can accept this cycle
cdb_valid  output  CDB_WIDTH  broadcast slot j carries a result
cdb_packet  output  CDB_WIDTH x CO_RE_PACKET  broadcast payload, field-for-field pass-through plus regfile_en/idx/data
free_alu  output  NUM_FU_ALU  one-cycle FU release pulses
free_mult  output  NUM_FU_MULT  one-cycle FU release pulses
free_branch  output  NUM_FU_BRANCH  one-cycle FU release pulses
free_load  output  NUM_FU_LOAD  one-cycle FU release pulses
free_store  output  NUM_FU_STORE  one-cycle FU release pulses

Behaviour:
- Reset values (reset==0 at an edge):
  - all FIFOs empty, rr_ptr=0.
  - cdb_valid=0, cdb_packet=0, all free_* = 0.
  - lane_ready=0 while reset is low.
- Enqueue:
  - lane i writes at the edge when lane_valid[i] && lane_ready[i].
  - lane_ready[i] = reset && !squash_en && (count[i] < BUF_DEPTH).
  - lane_ready is computed from the registered count only. A full FIFO stays not-ready even when it dequeues in the same cycle.
- Arbitration (combinational, over non-empty FIFO heads):
  - scan lanes from rr_ptr upward, modulo NUM_LANES; grant the first min(CDB_WIDTH, nonempty) lanes, at most one entry per lane per cycle.
  - slot j receives the j-th granted lane in scan order.
  - rr_ptr <= (last granted lane + 1) mod NUM_LANES; unchanged if no grant.
- Dequeue and broadcast:
  - granted heads pop at the edge and their packets are loaded into the cdb registers; ungranted slots load cdb_valid=0.
  - A packet enqueued at edge k is visible on cdb no earlier than after edge k+1 (minimum latency 2 edges). No bypass path.
- Per-slot fields:
  - regfile_en = head.valid && dest_reg_idx != ZERO_REG
  - regfile_idx = dest_reg_idx
  - regfile_data = take_branch ? NPC : result
  - all other CO_RE_PACKET fields copied unchanged.
- Free pulses:
  - registered, asserted in the same cycle as the matching cdb_valid.
  - bit issued_fu_index of the vector chosen by function_type.
  - suppressed if halt or illegal, or if function_type is outside {ALU, MULT, LOAD, STORE, BRANCH}.
  - multiple slots OR into the vectors.
- Squash: squash_en high at an edge →
  - all FIFOs emptied, cdb_valid and free_* cleared next cycle.
  - inputs presented that cycle are dropped (lane_ready already 0).
  - rr_ptr is kept.
- Reset has priority over squash. Reset mid-operation discards all buffered results without emitting free pulses.
- FIFO pointers wrap modulo BUF_DEPTH. Count width is clog2(BUF_DEPTH)+1.
- Equal priority among lanes is guaranteed by round-robin: no lane starves for more than ceil(NUM_LANES/CDB_WIDTH) cycles while non-empty.

Decomposition:
- Shared package:
  - EX_CO_PACKET, CO_RE_PACKET, FUNC_UNIT_TYPE enum.
  - new macros NUM_CO_LANES and CDB_WIDTH.
  - existing ZERO_REG, XLEN, PHYS_REG_IDX_SZ, NUM_FU_* and MAX_FU_INDEX.
- Sub-module: complete_lane_fifo, instantiated NUM_LANES times.
  - parameter BUF_DEPTH.
  - ports: push, push_data, pop, clear, head, empty, full.
- Arbiter and output registers remain in complete_multi.

Test Plan:
- Single lane 0 pushes ALU op, dest p5, result 0x1234, fu_index 1 → two edges later cdb_valid=2'b01, regfile_en=1, idx=5, data=0x1234, free_alu=…0010 for exactly one cycle.
- All 4 lanes push simultaneously, rr_ptr=0 → cycle A slots = lanes 0,1; cycle B slots = lanes 2,3; rr_ptr returns to 0.
- Lane 2 pushes 3 ops back-to-back with no grants possible (other lanes saturated by design of stimulus) → lane_ready[2] drops after 2 accepted; third is held by the lane and accepted once a pop occurs; no loss, order preserved.
- BRANCH op with take_branch=1, NPC=0x40, dest p7 → data=0x40; JAL to ZERO_REG → regfile_en=0, free_branch still pulses.
- Halt op valid → broadcast with halt=1, no free_* pulse.
- FIFOs half full, squash_en for one cycle with lane_valid high → next cycle cdb_valid=0, all counts 0, no free pulses, lane_ready=1 afterwards.
- Repeat the half-full setup with reset=0 instead of squash → same result, plus rr_ptr=0.

Source files
------------

// File: rtl/complete_multi_pkg.sv
// complete_multi_pkg: packet types and sizing constants shared by the multi-lane complete stage.
package complete_multi_pkg;
    localparam int XLEN            = 32;
    localparam int PHYS_REG_IDX_SZ = 6;
    localparam logic [PHYS_REG_IDX_SZ-1:0] ZERO_REG = '0;
    localparam int NUM_FU_ALU      = 3;
    localparam int NUM_FU_MULT     = 2;
    localparam int NUM_FU_BRANCH   = 1;
    localparam int NUM_FU_LOAD     = 2;
    localparam int NUM_FU_STORE    = 2;
    localparam int MAX_FU_INDEX    = 4;
    localparam int FU_IDX_SZ       = $clog2(MAX_FU_INDEX);
    localparam int NUM_CO_LANES    = 4;
    localparam int CDB_WIDTH       = 2;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_MULT   = 3'd2,
        FU_LOAD   = 3'd3,
        FU_STORE  = 3'd4,
        FU_BRANCH = 3'd5
    } FUNC_UNIT_TYPE;

    typedef struct packed {
        logic                       valid;
        logic [XLEN-1:0]            PC;
        logic [XLEN-1:0]            NPC;
        logic [XLEN-1:0]            result;
        logic                       take_branch;
        logic [PHYS_REG_IDX_SZ-1:0] dest_reg_idx;
        FUNC_UNIT_TYPE              function_type;
        logic [FU_IDX_SZ-1:0]       issued_fu_index;
        logic                       halt;
        logic                       illegal;
    } EX_CO_PACKET;

    typedef struct packed {
        EX_CO_PACKET                ex;
        logic                       regfile_en;
        logic [PHYS_REG_IDX_SZ-1:0] regfile_idx;
        logic [XLEN-1:0]            regfile_data;
    } CO_RE_PACKET;

    function automatic CO_RE_PACKET to_co_re(input EX_CO_PACKET p);
        return '{ex: p,
                 regfile_en: p.valid && p.dest_reg_idx != ZERO_REG,
                 regfile_idx: p.dest_reg_idx,
                 regfile_data: p.take_branch ? p.NPC : p.result};
    endfunction
endpackage

// File: rtl/complete_lane_fifo.sv
// complete_lane_fifo: per-lane holding queue for finished execute results.
module complete_lane_fifo
    import complete_multi_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  EX_CO_PACKET push_data,
    input  logic        pop,
    input  logic        clear,
    output EX_CO_PACKET head,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    EX_CO_PACKET   mem_q [BUF_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    assign head  = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(BUF_DEPTH);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/complete_multi.sv
// complete_multi: buffers per-lane execute results and broadcasts up to CDB_WIDTH per cycle
// round-robin, with registered CDB slots and one-cycle functional-unit release pulses.
module complete_multi #(
    parameter int NUM_LANES = complete_multi_pkg::NUM_CO_LANES,
    parameter int CDB_WIDTH = complete_multi_pkg::CDB_WIDTH,
    parameter int BUF_DEPTH = 2
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                squash_en,
    input  logic [NUM_LANES-1:0]                                lane_valid,
    input  complete_multi_pkg::EX_CO_PACKET [NUM_LANES-1:0]     lane_packet,
    output logic [NUM_LANES-1:0]                                lane_ready,
    output logic [CDB_WIDTH-1:0]                                cdb_valid,
    output complete_multi_pkg::CO_RE_PACKET [CDB_WIDTH-1:0]     cdb_packet,
    output logic [complete_multi_pkg::NUM_FU_ALU-1:0]           free_alu,
    output logic [complete_multi_pkg::NUM_FU_MULT-1:0]          free_mult,
    output logic [complete_multi_pkg::NUM_FU_BRANCH-1:0]        free_branch,
    output logic [complete_multi_pkg::NUM_FU_LOAD-1:0]          free_load,
    output logic [complete_multi_pkg::NUM_FU_STORE-1:0]         free_store
);
    import complete_multi_pkg::*;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    EX_CO_PACKET                  head [NUM_LANES];
    logic [NUM_LANES-1:0]         empty, full, push, grant;
    logic [LW-1:0]                rr_q, rr_d, scan;
    logic [LW-1:0]                slot_lane [CDB_WIDTH];
    int                           slot_n;
    EX_CO_PACKET                  cur;
    logic                         rel;
    logic [CDB_WIDTH-1:0]         cdb_valid_q, cdb_valid_d;
    CO_RE_PACKET [CDB_WIDTH-1:0]  cdb_packet_q, cdb_packet_d;
    logic [NUM_FU_ALU-1:0]        free_alu_q, free_alu_d;
    logic [NUM_FU_MULT-1:0]       free_mult_q, free_mult_d;
    logic [NUM_FU_BRANCH-1:0]     free_branch_q, free_branch_d;
    logic [NUM_FU_LOAD-1:0]       free_load_q, free_load_d;
    logic [NUM_FU_STORE-1:0]      free_store_q, free_store_d;

    // Ready depends on the registered count only, so a full lane stays blocked even while popping.
    assign lane_ready = {NUM_LANES{reset && !squash_en}} & ~full;
    assign push       = lane_valid & lane_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        complete_lane_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[i]),
            .push_data (lane_packet[i]),
            .pop       (grant[i]),
            .clear     (squash_en),
            .head      (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

    always_comb begin
        grant  = '0;
        rr_d   = rr_q;
        scan   = '0;
        slot_n = 0;
        for (int s = 0; s < CDB_WIDTH; s++) slot_lane[s] = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            scan = LW'((int'(rr_q) + k) % NUM_LANES);
            if (!empty[scan] && slot_n < CDB_WIDTH) begin
                grant[scan] = 1'b1;
                for (int s = 0; s < CDB_WIDTH; s++) if (s == slot_n) slot_lane[s] = scan;
                slot_n = slot_n + 1;
                rr_d   = LW'((int'(scan) + 1) % NUM_LANES);
            end
        end
    end

    always_comb begin
        cdb_valid_d   = '0;
        cdb_packet_d  = '0;
        free_alu_d    = '0;
        free_mult_d   = '0;
        free_branch_d = '0;
        free_load_d   = '0;
        free_store_d  = '0;
        cur           = '0;
        rel           = 1'b0;
        for (int s = 0; s < CDB_WIDTH; s++) begin
            cur             = head[slot_lane[s]];
            rel             = (s < slot_n) && !cur.halt && !cur.illegal;
            cdb_valid_d[s]  = s < slot_n;
            cdb_packet_d[s] = (s < slot_n) ? to_co_re(cur) : '0;
            free_alu_d    |= (rel && cur.function_type == FU_ALU)    ? (NUM_FU_ALU'(1)    << cur.issued_fu_index) : '0;
            free_mult_d   |= (rel && cur.function_type == FU_MULT)   ? (NUM_FU_MULT'(1)   << cur.issued_fu_index) : '0;
            free_branch_d |= (rel && cur.function_type == FU_BRANCH) ? (NUM_FU_BRANCH'(1) << cur.issued_fu_index) : '0;
            free_load_d   |= (rel && cur.function_type == FU_LOAD)   ? (NUM_FU_LOAD'(1)   << cur.issued_fu_index) : '0;
            free_store_d  |= (rel && cur.function_type == FU_STORE)  ? (NUM_FU_STORE'(1)  << cur.issued_fu_index) : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_q          <= '0;
            cdb_valid_q   <= '0;
            cdb_packet_q  <= '0;
            free_alu_q    <= '0;
            free_mult_q   <= '0;
            free_branch_q <= '0;
            free_load_q   <= '0;
            free_store_q  <= '0;
        end else if (squash_en) begin
            cdb_valid_q   <= '0;
            free_alu_q    <= '0;
            free_mult_q   <= '0;
            free_branch_q <= '0;
            free_load_q   <= '0;
            free_store_q  <= '0;
        end else begin
            rr_q          <= rr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_packet_q  <= cdb_packet_d;
            free_alu_q    <= free_alu_d;
            free_mult_q   <= free_mult_d;
            free_branch_q <= free_branch_d;
            free_load_q   <= free_load_d;
            free_store_q  <= free_store_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_packet  = cdb_packet_q;
    assign free_alu    = free_alu_q;
    assign free_mult   = free_mult_q;
    assign free_branch = free_branch_q;
    assign free_load   = free_load_q;
    assign free_store  = free_store_q;
endmodule

// File: tb/tb_complete_multi.sv
// tb_complete_multi: directed and random stimulus checked against a queue-based model of the complete stage.
module tb_complete_multi;
    import complete_multi_pkg::*;
    localparam int NL = 4;
    localparam int CW = 2;
    localparam int BD = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic squash_en = 1'b0;
    logic [NL-1:0] lane_valid = '0;
    logic [NL-1:0] lane_ready;
    EX_CO_PACKET [NL-1:0] lane_packet = '0;
    logic [CW-1:0] cdb_valid;
    CO_RE_PACKET [CW-1:0] cdb_packet;
    logic [NUM_FU_ALU-1:0] free_alu;
    logic [NUM_FU_MULT-1:0] free_mult;
    logic [NUM_FU_BRANCH-1:0] free_branch;
    logic [NUM_FU_LOAD-1:0] free_load;
    logic [NUM_FU_STORE-1:0] free_store;

    int checks = 0;
    int errors = 0;

    EX_CO_PACKET q [NL][$];
    int rr = 0;
    logic [CW-1:0] e_valid = '0;
    CO_RE_PACKET e_pkt [CW];
    logic [NUM_FU_ALU-1:0] e_alu;
    logic [NUM_FU_MULT-1:0] e_mult;
    logic [NUM_FU_BRANCH-1:0] e_branch;
    logic [NUM_FU_LOAD-1:0] e_load;
    logic [NUM_FU_STORE-1:0] e_store;
    logic [NL-1:0] e_ready, acc;

    always #5 clock = ~clock;

    complete_multi #(.NUM_LANES(NL), .CDB_WIDTH(CW), .BUF_DEPTH(BD)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash_en   (squash_en),
        .lane_valid  (lane_valid),
        .lane_packet (lane_packet),
        .lane_ready  (lane_ready),
        .cdb_valid   (cdb_valid),
        .cdb_packet  (cdb_packet),
        .free_alu    (free_alu),
        .free_mult   (free_mult),
        .free_branch (free_branch),
        .free_load   (free_load),
        .free_store  (free_store)
    );

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic EX_CO_PACKET mk(FUNC_UNIT_TYPE ft, int dest, logic [31:0] res, logic [31:0] npc,
                                       bit tk, int fu, bit hlt, bit ill);
        EX_CO_PACKET p;
        p.valid           = 1'b1;
        p.PC              = res ^ 32'hA5A5_0000;
        p.NPC             = npc;
        p.result          = res;
        p.take_branch     = tk;
        p.dest_reg_idx    = dest[PHYS_REG_IDX_SZ-1:0];
        p.function_type   = ft;
        p.issued_fu_index = fu[FU_IDX_SZ-1:0];
        p.halt            = hlt;
        p.illegal         = ill;
        return p;
    endfunction

    function automatic EX_CO_PACKET rnd_pkt();
        EX_CO_PACKET p;
        p.valid           = $urandom_range(7) != 0;
        p.PC              = $urandom;
        p.NPC             = $urandom;
        p.result          = $urandom;
        p.take_branch     = $urandom_range(1) == 1;
        p.dest_reg_idx    = ($urandom_range(3) == 0) ? '0 : PHYS_REG_IDX_SZ'($urandom);
        p.function_type   = FUNC_UNIT_TYPE'($urandom_range(7));
        p.issued_fu_index = FU_IDX_SZ'($urandom);
        p.halt            = $urandom_range(7) == 0;
        p.illegal         = $urandom_range(7) == 0;
        return p;
    endfunction

    function automatic CO_RE_PACKET expect_pkt(EX_CO_PACKET p);
        CO_RE_PACKET r;
        r.ex           = p;
        r.regfile_en   = p.valid && p.dest_reg_idx != 0;
        r.regfile_idx  = p.dest_reg_idx;
        r.regfile_data = p.take_branch ? p.NPC : p.result;
        return r;
    endfunction

    task automatic add_free(EX_CO_PACKET p);
        int f = int'(p.issued_fu_index);
        if (p.halt || p.illegal) return;
        if (p.function_type == FU_ALU && f < NUM_FU_ALU) e_alu[f] = 1'b1;
        if (p.function_type == FU_MULT && f < NUM_FU_MULT) e_mult[f] = 1'b1;
        if (p.function_type == FU_BRANCH && f < NUM_FU_BRANCH) e_branch[f] = 1'b1;
        if (p.function_type == FU_LOAD && f < NUM_FU_LOAD) e_load[f] = 1'b1;
        if (p.function_type == FU_STORE && f < NUM_FU_STORE) e_store[f] = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int n = 0;
        int nrr = rr;
        bit rdy [NL];
        {e_alu, e_mult, e_branch, e_load, e_store} = '0;
        e_valid = '0;
        if (!reset || squash_en) begin
            for (int l = 0; l < NL; l++) q[l].delete();
            if (!reset) begin
                rr = 0;
                for (int s = 0; s < CW; s++) e_pkt[s] = '0;
            end
            return;
        end
        for (int l = 0; l < NL; l++) rdy[l] = q[l].size() < BD;
        for (int k = 0; k < NL; k++) begin
            int l = (rr + k) % NL;
            if (q[l].size() > 0 && n < CW) begin
                EX_CO_PACKET p = q[l].pop_front();
                e_valid[n] = 1'b1;
                e_pkt[n]   = expect_pkt(p);
                add_free(p);
                n++;
                nrr = (l + 1) % NL;
            end
        end
        rr = nrr;
        for (int l = 0; l < NL; l++) if (lane_valid[l] && rdy[l]) q[l].push_back(lane_packet[l]);
    endtask

    task automatic step(string tag);
        #1;
        for (int l = 0; l < NL; l++) e_ready[l] = reset && !squash_en && q[l].size() < BD;
        chk({tag, " lane_ready"}, lane_ready, e_ready);
        acc = lane_valid & e_ready;
        model_edge();
        @(posedge clock);
        #1;
        chk({tag, " cdb_valid"}, cdb_valid, e_valid);
        for (int s = 0; s < CW; s++)
            if (e_valid[s] || !reset) chk($sformatf("%s cdb_packet%0d", tag, s), cdb_packet[s], e_pkt[s]);
        chk({tag, " free"}, {free_alu, free_mult, free_branch, free_load, free_store},
            {e_alu, e_mult, e_branch, e_load, e_store});
    endtask

    task automatic run(int cycles, int p_new, int sq_pct, int rst_pm);
        for (int c = 0; c < cycles; c++) begin
            for (int l = 0; l < NL; l++)
                if (!lane_valid[l] && $urandom_range(99) < p_new) begin
                    lane_packet[l] = rnd_pkt();
                    lane_valid[l]  = 1'b1;
                end
            squash_en = $urandom_range(99) < sq_pct;
            reset     = !($urandom_range(999) < rst_pm);
            step("rand");
            lane_valid = lane_valid & ~acc;
        end
        squash_en = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic reset_pulse();
        lane_valid = '0;
        reset = 1'b0;
        step("rst_pulse");
        reset = 1'b1;
    endtask

    task automatic push_all(int base);
        for (int l = 0; l < NL; l++) lane_packet[l] = mk(FU_MULT, l + 8, 32'(base + l), 32'h0, 1'b0, l % 2, 1'b0, 1'b0);
        lane_valid = '1;
    endtask

    initial begin
        // Reset state
        step("reset0");
        step("reset1");
        chk("reset cdb_valid", cdb_valid, '0);
        reset = 1'b1;

        // Single ALU op with two-edge latency
        lane_packet[0] = mk(FU_ALU, 5, 32'h1234, 32'h0, 1'b0, 1, 1'b0, 1'b0);
        lane_valid = 4'b0001;
        step("alu_push");
        chk("alu not yet", cdb_valid, '0);
        lane_valid = '0;
        step("alu_out");
        chk("alu valid", cdb_valid, 2'b01);
        chk("alu regfile_en", cdb_packet[0].regfile_en, 1'b1);
        chk("alu regfile_idx", cdb_packet[0].regfile_idx, 6'd5);
        chk("alu regfile_data", cdb_packet[0].regfile_data, 32'h1234);
        chk("alu free", free_alu, 3'b010);
        step("alu_idle");
        chk("alu free gone", free_alu, '0);

        // Four lanes at once from rr=0
        reset_pulse();
        push_all(32'h100);
        step("rr_push");
        lane_valid = '0;
        step("rr_a");
        chk("rr_a slot0", cdb_packet[0].regfile_data, 32'h100);
        chk("rr_a slot1", cdb_packet[1].regfile_data, 32'h101);
        step("rr_b");
        chk("rr_b slot0", cdb_packet[0].regfile_data, 32'h102);
        chk("rr_b slot1", cdb_packet[1].regfile_data, 32'h103);
        lane_packet[0] = mk(FU_ALU, 1, 32'h110, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        lane_packet[3] = mk(FU_ALU, 2, 32'h113, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        lane_valid = 4'b1001;
        step("rr_wrap_push");
        lane_valid = '0;
        step("rr_wrap");
        chk("rr_wrap slot0", cdb_packet[0].regfile_data, 32'h110);
        chk("rr_wrap slot1", cdb_packet[1].regfile_data, 32'h113);

        // Backpressure: lanes 2,3 fill while 0,1 are served
        reset_pulse();
        push_all(32'h180);
        step("fill1");
        push_all(32'h190);
        step("fill2");
        chk("full lane_ready", lane_ready, 4'b0011);
        lane_packet[2] = mk(FU_LOAD, 9, 32'h1A2, 32'h0, 1'b0, 1, 1'b0, 1'b0);
        lane_valid = 4'b0100;
        run(16, 100, 0, 0);
        lane_valid = '0;
        for (int i = 0; i < 6; i++) step("drain");

        // Branch with NPC, JAL to zero register, then halt
        reset_pulse();
        lane_packet[0] = mk(FU_BRANCH, 7, 32'h99, 32'h40, 1'b1, 0, 1'b0, 1'b0);
        lane_packet[1] = mk(FU_BRANCH, 0, 32'h98, 32'h80, 1'b1, 0, 1'b0, 1'b0);
        lane_valid = 4'b0011;
        step("br_push");
        lane_valid = '0;
        step("br_out");
        chk("br data", cdb_packet[0].regfile_data, 32'h40);
        chk("jal regfile_en", cdb_packet[1].regfile_en, 1'b0);
        chk("br free", free_branch, 1'b1);
        lane_packet[0] = mk(FU_ALU, 3, 32'h77, 32'h0, 1'b0, 2, 1'b1, 1'b0);
        lane_valid = 4'b0001;
        step("halt_push");
        lane_valid = '0;
        step("halt_out");
        chk("halt valid", cdb_valid, 2'b01);
        chk("halt bit", cdb_packet[0].ex.halt, 1'b1);
        chk("halt free", {free_alu, free_mult, free_branch, free_load, free_store}, '0);

        // Squash with half-full queues keeps rr (rr=3 here)
        push_all(32'h200);
        step("sq_fill1");
        push_all(32'h210);
        step("sq_fill2");
        squash_en = 1'b1;
        step("squash");
        chk("squash cdb_valid", cdb_valid, '0);
        chk("squash free", {free_alu, free_mult, free_branch, free_load, free_store}, '0);
        squash_en = 1'b0;
        lane_valid = '0;
        step("sq_idle");
        chk("squash ready after", lane_ready, 4'b1111);
        lane_packet[0] = mk(FU_ALU, 4, 32'h300, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        lane_packet[3] = mk(FU_ALU, 6, 32'h303, 32'h0, 1'b0, 1, 1'b0, 1'b0);
        lane_valid = 4'b1001;
        step("sq_push");
        lane_valid = '0;
        step("sq_out");
        chk("squash rr kept slot0", cdb_packet[0].regfile_data, 32'h303);
        chk("squash rr kept slot1", cdb_packet[1].regfile_data, 32'h300);

        // Same setup with reset instead: rr returns to 0
        push_all(32'h400);
        step("rs_fill1");
        push_all(32'h410);
        step("rs_fill2");
        reset = 1'b0;
        step("mid_reset");
        chk("reset cdb_valid", cdb_valid, '0);
        chk("reset free", {free_alu, free_mult, free_branch, free_load, free_store}, '0);
        reset = 1'b1;
        lane_valid = '0;
        step("rs_idle");
        chk("reset ready after", lane_ready, 4'b1111);
        lane_packet[0] = mk(FU_ALU, 4, 32'h300, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        lane_packet[3] = mk(FU_ALU, 6, 32'h303, 32'h0, 1'b0, 1, 1'b0, 1'b0);
        lane_valid = 4'b1001;
        step("rs_push");
        lane_valid = '0;
        step("rs_out");
        chk("reset rr slot0", cdb_packet[0].regfile_data, 32'h300);
        chk("reset rr slot1", cdb_packet[1].regfile_data, 32'h303);

        // Randomized traffic with occasional squash and reset
        run(600, 70, 0, 0);
        run(1500, 50, 3, 6);
        lane_valid = '0;
        for (int i = 0; i < 6; i++) step("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
